mux_scan_controller: RTL
========================

# mux_scan_controller

Round-robin scan controller that drives the 2-bit select lines of the gate-level 4:1 multiplexer and captures its single-bit output per channel. Requesting channels are served in round-robin order. Each granted channel holds `sel` for a programmable dwell time so the mux output settles. The settled `Y` value is then latched into a per-channel sample register. The block sits directly around the mux: `sel` feeds the mux and the mux `Y` returns as `y_in`.

## Interface
Parameters:
- `DWELL`, default 4: cycles `sel` is held per grant; legal range 1..255.
- `CW`, default 8: dwell counter width; must satisfy 2^CW > DWELL.

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `en`  input  1: scan enable; new grants are issued only while high.
- `req`  input  4: per-channel service request, level-sensitive.
- `y_in`  input  1: mux output `Y` for the currently selected channel.
- `sel`  output  2: mux select, registered.
- `active`  output  1: high while a grant is in progress (DWELL state).
- `sample`  output  4: bit i holds the last captured `y_in` for channel i.
- `ch_done`  output  4: one-hot, one-cycle pulse marking the channel just captured.
- `sample_vld`  output  1: one-cycle pulse, equal to `|ch_done`.

## Operation
- State machine has two states:
  - IDLE: no grant in progress.
  - DWELL: a grant is in progress.
- Round-robin pointer `ptr[1:0]` is the first channel considered.
  - Winner = first i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `req[i]` high.
  - A channel that was just served is considered last.
- IDLE, `en` high and `|req` high:
  - `sel` <= winner; counter <= DWELL-1; `active` <= 1; go to DWELL.
- IDLE, otherwise: stay in IDLE; `sel` holds its last value.
- DWELL, counter != 0: decrement the counter; `sel` is unchanged.
- DWELL, counter == 0 (the capture edge):
  - `sample[sel]` <= `y_in`; all other `sample` bits are unchanged.
  - `ch_done[sel]` <= 1; `sample_vld` <= 1.
  - `ptr` <= `sel`+1 (mod 4).
  - If `en` and `|req` are high at this edge, re-arbitrate from `sel`+1, load the new `sel`, reload counter to DWELL-1, and stay in DWELL (back-to-back grant, no idle cycle).
  - Otherwise go to IDLE; `active` <= 0.
- `req` is sampled only at arbitration edges. Dropping `req` mid-dwell does not abort the grant.
- `en` falling mid-dwell: the current grant completes and captures, then the block goes to IDLE.
- Only one requester: it is re-granted back-to-back indefinitely.
- Counter arithmetic is unsigned, CW bits, and never wraps, because it is reloaded before reaching 0-1.
- Reset values: `sel`=0, `active`=0, `sample`=0, `ch_done`=0, `sample_vld`=0, `ptr`=0, counter=0, state=IDLE.

## Timing
- Grant latency: `req` seen in IDLE at edge t gives `sel`/`active` valid after t.
- `sel` is stable for exactly DWELL cycles per grant.
- Capture happens at the DWELL-th edge after the grant. `ch_done`/`sample_vld` are high for the one cycle that follows.
- `sample` is updated on the same edge that raises `ch_done`.
- Back-to-back throughput: one capture every DWELL cycles.
- `y_in` is sampled only at the capture edge. The mux path must settle within DWELL-1 cycles plus combinational delay.
- `rst_n` low at any time, including mid-dwell:
  - All registers go to reset values immediately, without waiting for a clock edge.
  - No `ch_done` pulse is produced for the aborted grant.
- Reset is released synchronously to `clk` by the system. The first grant is possible on the first edge after release.

## Test plan
- Reset/idle:
  - Stimulus: hold `rst_n`=0, then release with `req`=0000.
  - Response: all outputs stay 0 and state stays IDLE for 20 cycles.
- Round-robin, DWELL=4, `en`=1:
  - Stimulus: `req`=1111 held; `y_in` = channel pattern 1,0,1,1.
  - Response: `sel` sequence 0,1,2,3,0, each held 4 cycles.
  - Response: `ch_done` pulses 0001,0010,0100,1000 every 4 cycles; `sample`=1101 after the first lap.
- Skip and fairness:
  - Stimulus: `req`=1010.
  - Response: `sel` alternates 1,3,1,3; channels 0 and 2 are never selected.
- Single requester, DWELL=1:
  - Stimulus: `req`=0100.
  - Response: `sel`=2 continuously; `sample_vld` high every cycle; `active` stays 1.
- Mid-dwell events, DWELL=4:
  - Stimulus: drop `req` and `en` one cycle after a grant to channel 1.
  - Response: the capture still occurs 3 cycles later (`ch_done`=0010), then IDLE with `active`=0.
- Asynchronous reset mid-dwell:
  - Stimulus: assert `rst_n`=0 between clock edges during a grant to channel 3.
  - Response: `sel`=0, `active`=0, and `sample`=0 before the next edge; no `ch_done` pulse.

Source files
------------

// File: rtl/mux_scan_controller.sv
// Round-robin scan controller wrapped around a 4:1 mux.
// Grants requesting channels in round-robin order and holds sel for DWELL
// cycles so the mux output can settle. At the end of the dwell it latches
// y_in into sample[sel] and pulses ch_done / sample_vld.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   en         - scan enable, new grants issued only while high
//   req[3:0]   - per-channel level-sensitive service request
//   y_in       - mux output for the currently selected channel
//   sel[1:0]   - registered mux select
//   active     - high while a grant is in progress
//   sample[3:0]- last captured y_in per channel
//   ch_done    - one-hot single-cycle pulse for the channel just captured
//   sample_vld - single-cycle pulse, equal to |ch_done
module mux_scan_controller #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       y_in,
    output logic [1:0] sel,
    output logic       active,
    output logic [3:0] sample,
    output logic [3:0] ch_done,
    output logic       sample_vld
);

    localparam int unsigned NCH    = 4;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    typedef enum logic {
        ST_IDLE,
        ST_DWELL
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      ptr, ptr_n;
    logic [1:0]      sel_n;
    logic            active_n;
    logic [NCH-1:0]  sample_n;
    logic [NCH-1:0]  ch_done_n;

    // First requesting channel in the order base, base+1, base+2, base+3.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] w;
        logic [1:0] idx;
        w = base;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = base + 2'(k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        sel_n     = sel;
        active_n  = active;
        sample_n  = sample;
        ch_done_n = '0;
        case (state)
            ST_IDLE: begin
                if (en && (|req)) begin
                    sel_n    = pick(req, ptr);
                    cnt_n    = RELOAD;
                    active_n = 1'b1;
                    state_n  = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    // Capture edge: latch the settled mux output.
                    sample_n[sel] = y_in;
                    ch_done_n     = 4'(4'b0001 << sel);
                    ptr_n         = sel + 2'd1;
                    if (en && (|req)) begin
                        // Back-to-back grant; the just-served channel ranks last.
                        sel_n = pick(req, sel + 2'd1);
                        cnt_n = RELOAD;
                    end else begin
                        active_n = 1'b0;
                        state_n  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n  = ST_IDLE;
                active_n = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ptr        <= '0;
            sel        <= '0;
            active     <= 1'b0;
            sample     <= '0;
            ch_done    <= '0;
            sample_vld <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            sel        <= sel_n;
            active     <= active_n;
            sample     <= sample_n;
            ch_done    <= ch_done_n;
            sample_vld <= |ch_done_n;
        end
    end

endmodule
